// File: rtl/gnn_seq_engine.sv
// Time-multiplexed two-layer GNN engine: one node per cycle through aggregate->W1->ReLU,
// then aggregate-hidden->W2 with results streamed out over valid/ready.
module gnn_seq_engine #(
  parameter int NUM_NODES = 4,
  parameter int NUM_FEAT  = 4,
  parameter int NUM_HID   = 4,
  parameter int NUM_OUT   = 2,
  parameter int XW        = 5,
  parameter int WW        = 5,
  localparam int NW  = $clog2(NUM_NODES),
  localparam int A1W = XW + $clog2(NUM_NODES),
  localparam int Y1W = A1W + WW + $clog2(NUM_FEAT),
  localparam int A2W = Y1W + $clog2(NUM_NODES),
  localparam int OW  = A2W + WW + $clog2(NUM_HID)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [NUM_NODES*NUM_NODES-1:0]     adj,
  input  logic [NUM_NODES*NUM_FEAT*XW-1:0]   x,
  input  logic [NUM_HID*NUM_FEAT*WW-1:0]     w1,
  input  logic [NUM_OUT*NUM_HID*WW-1:0]      w2,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [NW-1:0]                      out_node,
  output logic [NUM_OUT*OW-1:0]              out_data,
  output logic                               done
);

  // Handshake: a result transfers on a rising edge where out_valid=1 and out_ready=1;
  // out_node/out_data hold steady while out_valid=1 and out_ready=0.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAYER1 = 2'd1,
    LAYER2 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state, state_next;
  logic [NW-1:0] idx;

  logic [NUM_NODES-1:0]  adj_m  [NUM_NODES];
  logic signed [XW-1:0]  x_m    [NUM_NODES][NUM_FEAT];
  logic signed [WW-1:0]  w1_m   [NUM_HID][NUM_FEAT];
  logic signed [WW-1:0]  w2_m   [NUM_OUT][NUM_HID];
  logic signed [Y1W-1:0] hidden [NUM_NODES][NUM_HID];

  logic [NUM_NODES-1:0]  adj_row;
  logic signed [A1W-1:0] agg1  [NUM_FEAT];
  logic signed [Y1W-1:0] y1    [NUM_HID];
  logic signed [Y1W-1:0] relu1 [NUM_HID];
  logic signed [A2W-1:0] agg2  [NUM_HID];
  logic [NUM_OUT*OW-1:0] out_calc;
  logic signed [A1W-1:0] s1;
  logic signed [Y1W-1:0] s2;
  logic signed [A2W-1:0] s3;
  logic signed [OW-1:0]  s4;

  logic last_node;
  logic advance;
  logic accept;

  assign adj_row   = adj_m[idx];
  assign last_node = (idx == NW'(NUM_NODES - 1));
  assign advance   = (state == LAYER2) && (!out_valid || out_ready);
  assign accept    = out_valid && out_ready;
  assign busy      = (state != IDLE);

  // Layer 1 datapath for the node selected by idx.
  always_comb begin
    s1 = '0;
    s2 = '0;
    for (int f = 0; f < NUM_FEAT; f++) begin
      s1 = '0;
      for (int j = 0; j < NUM_NODES; j++) begin
        if (adj_row[j]) s1 = s1 + A1W'(x_m[j][f]);
      end
      agg1[f] = s1;
    end
    for (int h = 0; h < NUM_HID; h++) begin
      s2 = '0;
      for (int f = 0; f < NUM_FEAT; f++) begin
        s2 = s2 + Y1W'(agg1[f]) * Y1W'(w1_m[h][f]);
      end
      y1[h]    = s2;
      relu1[h] = s2[Y1W-1] ? '0 : s2;
    end
  end

  // Layer 2 datapath: aggregate hidden rows of the neighbours, then apply W2 (no ReLU).
  always_comb begin
    s3       = '0;
    s4       = '0;
    out_calc = '0;
    for (int h = 0; h < NUM_HID; h++) begin
      s3 = '0;
      for (int j = 0; j < NUM_NODES; j++) begin
        if (adj_row[j]) s3 = s3 + A2W'(hidden[j][h]);
      end
      agg2[h] = s3;
    end
    for (int o = 0; o < NUM_OUT; o++) begin
      s4 = '0;
      for (int h = 0; h < NUM_HID; h++) begin
        s4 = s4 + OW'(agg2[h]) * OW'(w2_m[o][h]);
      end
      out_calc[o*OW +: OW] = s4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LAYER1;
      LAYER1:  if (last_node) state_next = LAYER2;
      LAYER2:  if (advance && last_node) state_next = DRAIN;
      DRAIN:   if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      out_valid <= 1'b0;
      out_node  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) idx <= '0;
        end
        LAYER1: begin
          idx <= last_node ? '0 : idx + 1'b1;
        end
        LAYER2: begin
          if (advance) begin
            out_data  <= out_calc;
            out_node  <= idx;
            out_valid <= 1'b1;
            idx       <= last_node ? '0 : idx + 1'b1;
          end
        end
        DRAIN: begin
          if (accept) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Captured operands and the hidden buffer deliberately survive reset.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && start) begin
      for (int i = 0; i < NUM_NODES; i++)
        adj_m[i] <= adj[i*NUM_NODES +: NUM_NODES];
      for (int n = 0; n < NUM_NODES; n++)
        for (int f = 0; f < NUM_FEAT; f++)
          x_m[n][f] <= x[(n*NUM_FEAT+f)*XW +: XW];
      for (int h = 0; h < NUM_HID; h++)
        for (int f = 0; f < NUM_FEAT; f++)
          w1_m[h][f] <= w1[(h*NUM_FEAT+f)*WW +: WW];
      for (int o = 0; o < NUM_OUT; o++)
        for (int h = 0; h < NUM_HID; h++)
          w2_m[o][h] <= w2[(o*NUM_HID+h)*WW +: WW];
    end
    if (!rst && state == LAYER1) begin
      for (int h = 0; h < NUM_HID; h++)
        hidden[idx][h] <= relu1[h];
    end
  end

endmodule

// File: tb/tb_gnn_seq_engine.sv
// Directed bench for gnn_seq_engine: graph/weight vectors with hand-computed results,
// cycle-exact result/done timing, back-pressure, start filtering and mid-run reset.
module tb_gnn_seq_engine;
  localparam int N  = 4;
  localparam int F  = 4;
  localparam int H  = 4;
  localparam int O  = 2;
  localparam int XW = 5;
  localparam int WW = 5;
  localparam int OW = 23;
  localparam int DW = O * OW;

  localparam logic [N*N-1:0] ADJ_DIAMOND  = 16'hEDB7;
  localparam logic [N*N-1:0] ADJ_IDENTITY = 16'h8421;
  localparam logic [N*N-1:0] ADJ_ALL      = 16'hFFFF;

  logic               clk;
  logic               rst;
  logic               start;
  logic [N*N-1:0]     adj;
  logic [N*F*XW-1:0]  x;
  logic [H*F*WW-1:0]  w1;
  logic [O*H*WW-1:0]  w2;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_node;
  logic [DW-1:0]      out_data;
  logic               done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [DW-1:0] exp_q[$];

  gnn_seq_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .adj       (adj),
    .x         (x),
    .w1        (w1),
    .w2        (w2),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_node  (out_node),
    .out_data  (out_data),
    .done      (done)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [N*F*XW-1:0] fill_x(input int v, input bit rnd);
    logic [N*F*XW-1:0] r;
    r = '0;
    for (int i = 0; i < N*F; i++)
      r[i*XW +: XW] = rnd ? XW'($urandom_range(0, 31)) : XW'(v);
    return r;
  endfunction

  function automatic logic [H*F*WW-1:0] fill_w1(input int v, input bit rnd);
    logic [H*F*WW-1:0] r;
    r = '0;
    for (int i = 0; i < H*F; i++)
      r[i*WW +: WW] = rnd ? WW'($urandom_range(0, 31)) : WW'(v);
    return r;
  endfunction

  function automatic logic [O*H*WW-1:0] fill_w2(input int v, input bit rnd);
    logic [O*H*WW-1:0] r;
    r = '0;
    for (int i = 0; i < O*H; i++)
      r[i*WW +: WW] = rnd ? WW'($urandom_range(0, 31)) : WW'(v);
    return r;
  endfunction

  task automatic push_exp(input int val);
    logic signed [OW-1:0] v;
    v = OW'(val);
    exp_q.delete();
    repeat (N) exp_q.push_back({v, v});
  endtask

  task automatic load_diamond();
    adj = ADJ_DIAMOND;
    x   = fill_x(1, 1'b0);
    w1  = fill_w1(1, 1'b0);
    w2  = fill_w2(1, 1'b0);
    push_exp(144);
  endtask

  task automatic load_wide();
    adj = ADJ_ALL;
    x   = fill_x(-16, 1'b0);
    w1  = fill_w1(-16, 1'b0);
    w2  = fill_w2(-16, 1'b0);
    push_exp(-1048576);
  endtask

  // One run: start at E0 (cyc=0), observe every cycle, optional stall on one node,
  // optional stray start pulses plus input scrambling, optional chained start in done cycle.
  task automatic run(input string tag, input bit pre_started, input int stall_node,
                     input int stall_len, input bit scramble, input bit chain);
    int got;
    int first_seen;
    int stall_left;
    int exp_done;
    int exp_cyc;
    bit done_seen;
    got        = 0;
    first_seen = -1;
    stall_left = stall_len;
    done_seen  = 1'b0;
    exp_done   = 2*N + 1 + ((stall_node >= 0) ? stall_len : 0);
    out_ready  = 1'b1;
    if (!pre_started) start = 1'b1;
    tick();
    cyc   = 0;
    start = 1'b0;
    if (scramble) x = fill_x(0, 1'b1);
    while (!done_seen && cyc < 40) begin
      tick();
      start = scramble && (cyc == 3 || cyc == 8);
      if (out_valid) begin
        check({tag, ":node"}, 64'(out_node), 64'(got));
        if (exp_q.size() > 0) check({tag, ":data"}, 64'(out_data), 64'(exp_q[0]));
        if (first_seen != got) begin
          exp_cyc = N + 1 + got + ((stall_node >= 0 && got > stall_node) ? stall_len : 0);
          check({tag, ":res_cycle"}, 64'(cyc), 64'(exp_cyc));
          first_seen = got;
        end
        if (got == stall_node && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          got++;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (done) begin
        check({tag, ":done_cycle"}, 64'(cyc), 64'(exp_done));
        check({tag, ":count"}, 64'(got), 64'(N));
        check({tag, ":busy_at_done"}, 64'(busy), 64'(0));
        done_seen = 1'b1;
      end else begin
        check({tag, ":busy"}, 64'(busy), 64'(1));
      end
    end
    if (!done_seen) check({tag, ":done_timeout"}, 64'(0), 64'(1));
    if (chain) begin
      start = 1'b1;
    end else begin
      tick();
      check({tag, ":done_pulse"}, 64'(done), 64'(0));
      check({tag, ":idle_after"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    adj       = '0;
    x         = '0;
    w1        = '0;
    w2        = '0;
    repeat (3) tick();
    check("rst:busy",      64'(busy),      64'(0));
    check("rst:out_valid", 64'(out_valid), 64'(0));
    check("rst:done",      64'(done),      64'(0));
    check("rst:out_node",  64'(out_node),  64'(0));
    check("rst:out_data",  64'(out_data),  64'(0));
    rst = 1'b0;
    tick();

    load_diamond();
    run("diamond", 1'b0, -1, 0, 1'b0, 1'b0);

    load_wide();
    run("wide", 1'b0, -1, 0, 1'b0, 1'b0);

    adj = ADJ_IDENTITY;
    x   = fill_x(-16, 1'b0);
    w1  = fill_w1(1, 1'b0);
    w2  = fill_w2(1, 1'b0);
    push_exp(0);
    run("relu_clamp", 1'b0, -1, 0, 1'b0, 1'b0);

    adj = '0;
    x   = fill_x(0, 1'b1);
    w1  = fill_w1(0, 1'b1);
    w2  = fill_w2(0, 1'b1);
    push_exp(0);
    run("adj_zero", 1'b0, -1, 0, 1'b0, 1'b0);

    load_diamond();
    run("stall", 1'b0, 1, 3, 1'b0, 1'b0);

    load_diamond();
    run("start_ignored", 1'b0, -1, 0, 1'b1, 1'b1);
    load_wide();
    run("chained", 1'b1, -1, 0, 1'b0, 1'b0);

    // Reset in LAYER2 right after node 1 has been accepted.
    load_diamond();
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    cyc   = 0;
    start = 1'b0;
    while (cyc < 7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst:busy",      64'(busy),      64'(0));
    check("midrst:out_valid", 64'(out_valid), 64'(0));
    check("midrst:out_node",  64'(out_node),  64'(0));
    check("midrst:out_data",  64'(out_data),  64'(0));
    for (int i = 0; i < 12; i++) begin
      check("midrst:no_done", 64'(done), 64'(0));
      tick();
    end
    check("midrst:still_idle", 64'(busy), 64'(0));

    load_diamond();
    run("rerun", 1'b0, -1, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
